// File: rtl/number_grid_pkg.sv
// Shared types and constants for the collectable number grid.
// Positions are fixed point: pixels scaled by FIXED_POINT_MULTIPLIER.
package number_grid_pkg;

    typedef enum logic [1:0] {
        CELL_VISIBLE = 2'd0,
        CELL_HIDDEN  = 2'd1,
        CELL_BLINK   = 2'd2
    } cell_state_e;

    localparam int FIXED_POINT_MULTIPLIER = 64;
    localparam int FIXED_POINT_SHIFT      = 6;

    localparam logic [3:0] LFSR_SEED = 4'b1001;

    // Timer must hold the longer of the two countdowns, never narrower than 9 bits.
    function automatic int unsigned timer_width(input int unsigned hide, input int unsigned blink);
        int unsigned longest;
        int unsigned w;
        longest = (hide > blink) ? hide : blink;
        w = $clog2(longest + 1);
        return (w < 9) ? 9 : w;
    endfunction

endpackage

// File: rtl/number_cell_fsm.sv
// Visibility FSM of one grid cell: visible -> hidden -> (blink) -> visible.
// showNum is registered; respawn flags the edge on which the cell becomes visible again.
module number_cell_fsm
    import number_grid_pkg::*;
#(
    parameter int unsigned HIDE_FRAMES  = 450,
    parameter int unsigned BLINK_FRAMES = 60,
    parameter int unsigned BLINK_PERIOD = 8,
    parameter int unsigned TIMER_W      = 9
) (
    input  logic clk,
    input  logic reset,
    input  logic startOfFrame,
    input  logic hitAccept,
    output logic visible,
    output logic showNum,
    output logic respawn
);

    cell_state_e        state_q, state_d;
    logic [TIMER_W-1:0] timer_q, timer_d;
    logic               show_q, show_d;
    logic [TIMER_W-1:0] elapsed;

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        respawn = 1'b0;
        unique case (state_q)
            CELL_VISIBLE: begin
                if (hitAccept) begin
                    state_d = CELL_HIDDEN;
                    timer_d = TIMER_W'(HIDE_FRAMES);
                end
            end
            CELL_HIDDEN: begin
                if (startOfFrame) begin
                    if (timer_q == TIMER_W'(1)) begin
                        if (BLINK_FRAMES == 0) begin
                            state_d = CELL_VISIBLE;
                            timer_d = '0;
                            respawn = 1'b1;
                        end else begin
                            state_d = CELL_BLINK;
                            timer_d = TIMER_W'(BLINK_FRAMES);
                        end
                    end else begin
                        timer_d = timer_q - TIMER_W'(1);
                    end
                end
            end
            CELL_BLINK: begin
                if (startOfFrame) begin
                    if (timer_q == TIMER_W'(1)) begin
                        state_d = CELL_VISIBLE;
                        timer_d = '0;
                        respawn = 1'b1;
                    end else begin
                        timer_d = timer_q - TIMER_W'(1);
                    end
                end
            end
            default: begin
                state_d = CELL_VISIBLE;
                timer_d = '0;
            end
        endcase
    end

    // Odd half-periods since blink start are lit, so the blink opens dark.
    always_comb begin
        elapsed = TIMER_W'(BLINK_FRAMES) - timer_d;
        show_d  = 1'b0;
        if (state_d == CELL_VISIBLE) begin
            show_d = 1'b1;
        end else if (state_d == CELL_BLINK) begin
            show_d = 1'(elapsed / TIMER_W'(BLINK_PERIOD));
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= CELL_VISIBLE;
            timer_q <= '0;
            show_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            show_q  <= show_d;
        end
    end

    assign visible = (state_q == CELL_VISIBLE);
    assign showNum = show_q;

endmodule

// File: rtl/number_grid_controller.sv
// COLS x ROWS grid of collectable digits: per-column wrapping motion, per-cell visibility,
// lowest-index hit arbitration and a saturating hit counter.
module number_grid_controller
    import number_grid_pkg::*;
#(
    parameter int          COLS         = 3,
    parameter int          ROWS         = 3,
    parameter int          INITIAL_X    = 150,
    parameter int          X_DIFF       = 50,
    parameter int          INITIAL_Y    = 100,
    parameter int          Y_DIFF       = 100,
    parameter int          X_MIN        = 0,
    parameter int          X_MAX        = 600,
    parameter int unsigned HIDE_FRAMES  = 450,
    parameter int unsigned BLINK_FRAMES = 60,
    parameter int unsigned BLINK_PERIOD = 8,
    parameter bit          RANDOM_DIGIT = 1'b0,
    localparam int         NCELLS       = COLS * ROWS,
    localparam int         IDX_W        = (NCELLS > 1) ? $clog2(NCELLS) : 1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          startOfFrame,
    input  logic [NCELLS-1:0][3:0]        numbersToShow,
    input  logic [COLS-1:0][31:0]         columnSpeeds,
    input  logic [NCELLS-1:0]             cellHit,
    output logic [NCELLS-1:0]             showNum,
    output logic [NCELLS-1:0][3:0]        cellDigit,
    output logic [NCELLS-1:0][10:0]       cellX,
    output logic [NCELLS-1:0][10:0]       cellY,
    output logic                          hitValid,
    output logic [IDX_W-1:0]              hitIndex,
    output logic [3:0]                    hitDigit,
    output logic [15:0]                   hitCount
);

    localparam int unsigned     TIMER_W  = timer_width(HIDE_FRAMES, BLINK_FRAMES);
    localparam logic signed [31:0] X_MIN_FP = 32'(X_MIN * FIXED_POINT_MULTIPLIER);
    localparam logic signed [31:0] X_MAX_FP = 32'(X_MAX * FIXED_POINT_MULTIPLIER);
    localparam logic signed [31:0] SPAN_FP  = 32'((X_MAX - X_MIN) * FIXED_POINT_MULTIPLIER);

    logic [COLS-1:0][31:0]  colPos;
    logic [NCELLS-1:0]      visible;
    logic [NCELLS-1:0]      respawn;
    logic [NCELLS-1:0]      candidate;
    logic [NCELLS-1:0]      grant;
    logic                   found;
    logic [IDX_W-1:0]       winIdx;

    logic [3:0]             lfsr_q;
    logic [3:0]             lfsrDigit;

    logic                   hitValid_q;
    logic [IDX_W-1:0]       hitIndex_q;
    logic [3:0]             hitDigit_q;
    logic [15:0]            hitCount_q;

    // Fibonacci LFSR for x^4 + x^3 + 1; the seed is non-zero so it never locks up.
    always_ff @(posedge clk) begin
        if (reset) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= {lfsr_q[2:0], lfsr_q[3] ^ lfsr_q[2]};
        end
    end

    assign lfsrDigit = (lfsr_q >= 4'd10) ? (lfsr_q - 4'd10) : lfsr_q;

    for (genvar c = 0; c < COLS; c++) begin : g_col
        logic signed [31:0] pos_q;
        logic signed [31:0] sum;
        logic signed [31:0] wrapped;

        always_comb begin
            sum     = pos_q + $signed(columnSpeeds[c]);
            wrapped = sum;
            if (sum >= X_MAX_FP) begin
                wrapped = sum - SPAN_FP;
            end else if (sum < X_MIN_FP) begin
                wrapped = sum + SPAN_FP;
            end
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                pos_q <= 32'((INITIAL_X + c * X_DIFF) * FIXED_POINT_MULTIPLIER);
            end else if (startOfFrame) begin
                pos_q <= wrapped;
            end
        end

        assign colPos[c] = pos_q;
    end

    for (genvar i = 0; i < NCELLS; i++) begin : g_cell
        localparam int COL = i / ROWS;
        localparam int ROW = i % ROWS;

        logic [3:0] digit_q;

        number_cell_fsm #(
            .HIDE_FRAMES  (HIDE_FRAMES),
            .BLINK_FRAMES (BLINK_FRAMES),
            .BLINK_PERIOD (BLINK_PERIOD),
            .TIMER_W      (TIMER_W)
        ) u_cell_fsm (
            .clk          (clk),
            .reset        (reset),
            .startOfFrame (startOfFrame),
            .hitAccept    (grant[i]),
            .visible      (visible[i]),
            .showNum      (showNum[i]),
            .respawn      (respawn[i])
        );

        always_ff @(posedge clk) begin
            if (reset) begin
                digit_q <= numbersToShow[i];
            end else if (respawn[i]) begin
                digit_q <= RANDOM_DIGIT ? lfsrDigit : numbersToShow[i];
            end
        end

        assign cellDigit[i] = digit_q;
        assign cellX[i]     = 11'($signed(colPos[COL]) >>> FIXED_POINT_SHIFT);
        assign cellY[i]     = 11'(INITIAL_Y + ROW * Y_DIFF);
        assign candidate[i] = cellHit[i] & visible[i];
    end

    // Scan from the top so the lowest candidate index is the one left standing.
    always_comb begin
        grant  = '0;
        found  = 1'b0;
        winIdx = '0;
        for (int i = NCELLS - 1; i >= 0; i--) begin
            if (candidate[i]) begin
                found  = 1'b1;
                winIdx = IDX_W'(i);
            end
        end
        if (found) begin
            grant[winIdx] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hitValid_q <= 1'b0;
            hitIndex_q <= '0;
            hitDigit_q <= '0;
            hitCount_q <= '0;
        end else begin
            hitValid_q <= found;
            if (found) begin
                hitIndex_q <= winIdx;
                hitDigit_q <= cellDigit[winIdx];
                if (hitCount_q != 16'hFFFF) begin
                    hitCount_q <= hitCount_q + 16'd1;
                end
            end
        end
    end

    assign hitValid = hitValid_q;
    assign hitIndex = hitIndex_q;
    assign hitDigit = hitDigit_q;
    assign hitCount = hitCount_q;

endmodule

// File: tb/tb_number_grid_controller.sv
// Randomized and directed bench for number_grid_controller against a frame-count reference model.
module tb_number_grid_controller;

    localparam int COLS   = 3;
    localparam int ROWS   = 3;
    localparam int NCELLS = 9;
    localparam int HIDE   = 450;
    localparam int BLINK  = 60;
    localparam int BP     = 8;
    localparam int XMAXFP = 600 * 64;
    localparam int SPANFP = 600 * 64;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                     rst;
    logic                     sof;
    logic [NCELLS-1:0][3:0]   nums;
    logic [COLS-1:0][31:0]    speeds;
    logic [NCELLS-1:0]        hit;

    logic [NCELLS-1:0]        showNum;
    logic [NCELLS-1:0][3:0]   cellDigit;
    logic [NCELLS-1:0][10:0]  cellX;
    logic [NCELLS-1:0][10:0]  cellY;
    logic                     hitValid;
    logic [3:0]               hitIndex;
    logic [3:0]               hitDigit;
    logic [15:0]              hitCount;

    number_grid_controller u_dut (
        .clk           (clk),
        .reset         (rst),
        .startOfFrame  (sof),
        .numbersToShow (nums),
        .columnSpeeds  (speeds),
        .cellHit       (hit),
        .showNum       (showNum),
        .cellDigit     (cellDigit),
        .cellX         (cellX),
        .cellY         (cellY),
        .hitValid      (hitValid),
        .hitIndex      (hitIndex),
        .hitDigit      (hitDigit),
        .hitCount      (hitCount)
    );

    // Second instance with a one-frame respawn, used only to reach counter saturation quickly.
    logic                     sat_rst;
    logic [NCELLS-1:0]        sat_hit;
    logic [NCELLS-1:0]        sat_show;
    logic [NCELLS-1:0][3:0]   sat_digit;
    logic [NCELLS-1:0][10:0]  sat_x;
    logic [NCELLS-1:0][10:0]  sat_y;
    logic                     sat_valid;
    logic [3:0]               sat_index;
    logic [3:0]               sat_hdigit;
    logic [15:0]              sat_count;

    number_grid_controller #(
        .HIDE_FRAMES  (1),
        .BLINK_FRAMES (0)
    ) u_sat (
        .clk           (clk),
        .reset         (sat_rst),
        .startOfFrame  (1'b1),
        .numbersToShow ('0),
        .columnSpeeds  ('0),
        .cellHit       (sat_hit),
        .showNum       (sat_show),
        .cellDigit     (sat_digit),
        .cellX         (sat_x),
        .cellY         (sat_y),
        .hitValid      (sat_valid),
        .hitIndex      (sat_index),
        .hitDigit      (sat_hdigit),
        .hitCount      (sat_count)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    // Reference model: frames left hidden / blinking per cell, pixel*64 position per column.
    int         m_pos   [COLS];
    int         m_hide  [NCELLS];
    int         m_blink [NCELLS];
    logic [3:0] m_digit [NCELLS];
    bit         m_hv;
    int         m_hidx;
    logic [3:0] m_hdig;
    int         m_cnt;

    function automatic bit m_vis(input int i);
        return (m_hide[i] == 0) && (m_blink[i] == 0);
    endfunction

    function automatic logic m_show(input int i);
        if (m_hide[i] > 0) return 1'b0;
        if (m_blink[i] > 0) return (((BLINK - m_blink[i]) / BP) % 2) == 1;
        return 1'b1;
    endfunction

    task automatic model_step();
        int win;
        if (rst) begin
            for (int c = 0; c < COLS; c++) m_pos[c] = (150 + c * 50) * 64;
            for (int i = 0; i < NCELLS; i++) begin
                m_hide[i]  = 0;
                m_blink[i] = 0;
                m_digit[i] = nums[i];
            end
            m_hv  = 1'b0;
            m_cnt = 0;
            return;
        end
        win = -1;
        for (int i = 0; i < NCELLS; i++) if (win < 0 && hit[i] && m_vis(i)) win = i;
        m_hv = (win >= 0);
        if (win >= 0) begin
            m_hidx = win;
            m_hdig = m_digit[win];
            if (m_cnt < 65535) m_cnt++;
        end
        for (int i = 0; i < NCELLS; i++) begin
            if (i == win) begin
                m_hide[i] = HIDE;
            end else if (sof) begin
                if (m_hide[i] > 0) begin
                    m_hide[i]--;
                    if (m_hide[i] == 0) m_blink[i] = BLINK;
                end else if (m_blink[i] > 0) begin
                    m_blink[i]--;
                    if (m_blink[i] == 0) m_digit[i] = nums[i];
                end
            end
        end
        if (sof) begin
            for (int c = 0; c < COLS; c++) begin
                m_pos[c] += int'($signed(speeds[c]));
                if (m_pos[c] >= XMAXFP) m_pos[c] -= SPANFP;
                else if (m_pos[c] < 0) m_pos[c] += SPANFP;
            end
        end
    endtask

    task automatic compare_all();
        logic [NCELLS-1:0]       es;
        logic [NCELLS-1:0][10:0] ex;
        logic [NCELLS-1:0][3:0]  ed;
        for (int i = 0; i < NCELLS; i++) begin
            es[i] = m_show(i);
            ex[i] = 11'(m_pos[i / ROWS] / 64);
            ed[i] = m_digit[i];
        end
        check("showNum", 128'(showNum), 128'(es));
        check("hitValid", 128'(hitValid), 128'(m_hv));
        if (m_hv) begin
            check("hitIndex", 128'(hitIndex), 128'(m_hidx));
            check("hitDigit", 128'(hitDigit), 128'(m_hdig));
        end
        check("hitCount", 128'(hitCount), 128'(m_cnt));
        check("cellX", 128'(cellX), 128'(ex));
        check("cellDigit", 128'(cellDigit), 128'(ed));
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        compare_all();
    endtask

    task automatic frames(input int n);
        repeat (n) begin
            sof = 1'b1;
            tick();
            sof = 1'b0;
            tick();
        end
    endtask

    task automatic main_seq();
        int s;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        check("rst_show", 128'(showNum), 128'(9'h1FF));
        check("rst_x4", 128'(cellX[4]), 128'(200));
        check("rst_y4", 128'(cellY[4]), 128'(200));
        check("rst_cnt", 128'(hitCount), 128'(0));

        // Single hit, hide, blink, respawn with a new digit
        hit[4] = 1'b1;
        tick();
        hit = '0;
        check("t2_valid", 128'(hitValid), 128'(1));
        check("t2_index", 128'(hitIndex), 128'(4));
        check("t2_digit", 128'(hitDigit), 128'(nums[4]));
        nums[4] = (nums[4] + 4'd3) % 4'd10;
        frames(200);
        hit[4] = 1'b1;
        tick();
        hit = '0;
        check("t5_hidden_hit", 128'(hitValid), 128'(0));
        frames(249);
        check("t2_still_hidden", 128'(showNum[4]), 128'(0));
        frames(1);
        check("t2_blink_dark", 128'(showNum[4]), 128'(0));
        frames(7);
        check("t2_blink_dark7", 128'(showNum[4]), 128'(0));
        frames(1);
        check("t2_blink_lit", 128'(showNum[4]), 128'(1));
        hit = 9'b0_0001_0001;
        tick();
        hit = '0;
        check("t5_blink_hit", 128'(hitIndex), 128'(0));
        frames(51);
        frames(1);
        check("t2_respawn_show", 128'(showNum[4]), 128'(1));
        check("t2_respawn_digit", 128'(cellDigit[4]), 128'(nums[4]));

        // Reset while cells are hidden and blinking
        hit[1] = 1'b1;
        tick();
        hit = '0;
        frames(400);
        hit[2] = 1'b1;
        tick();
        hit = '0;
        frames(55);
        check("t6_pre_hidden", 128'(showNum[2]), 128'(0));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t6_show", 128'(showNum), 128'(9'h1FF));
        check("t6_x0", 128'(cellX[0]), 128'(150));
        check("t6_x8", 128'(cellX[8]), 128'(250));
        check("t6_cnt", 128'(hitCount), 128'(0));

        // Simultaneous hits: lowest index first, held loser next cycle
        hit[2] = 1'b1;
        hit[7] = 1'b1;
        tick();
        hit[2] = 1'b0;
        check("t3_first", 128'(hitIndex), 128'(2));
        tick();
        hit = '0;
        check("t3_second", 128'(hitIndex), 128'(7));
        tick();
        check("t3_quiet", 128'(hitValid), 128'(0));

        // Wrap-around in both directions
        speeds[0] = 32'(64 * 5);
        frames(89);
        check("t4_595", 128'(cellX[0]), 128'(595));
        speeds[0] = 32'(640);
        frames(1);
        check("t4_wrap_hi", 128'(cellX[0]), 128'(5));
        speeds[0] = 32'(-128);
        frames(1);
        check("t4_at3", 128'(cellX[0]), 128'(3));
        speeds[0] = 32'(-640);
        frames(1);
        check("t4_wrap_lo", 128'(cellX[0]), 128'(593));

        // Randomized traffic
        for (int n = 0; n < 4000; n++) begin
            sof = ($urandom_range(0, 3) == 0);
            for (int i = 0; i < NCELLS; i++) hit[i] = ($urandom_range(0, 15) == 0);
            if ($urandom_range(0, 63) == 0) begin
                for (int c = 0; c < COLS; c++) begin
                    s = int'($urandom_range(0, 76796)) - 38398;
                    speeds[c] = 32'(s);
                end
            end
            if ($urandom_range(0, 31) == 0) nums[$urandom_range(0, NCELLS - 1)] = 4'($urandom_range(0, 9));
            rst = ($urandom_range(0, 999) == 0);
            tick();
        end
        rst = 1'b0;
        sof = 1'b0;
        hit = '0;
    endtask

    task automatic sat_seq();
        sat_rst = 1'b1;
        sat_hit = '0;
        repeat (2) @(posedge clk);
        #1;
        sat_rst = 1'b0;
        sat_hit = '1;
        repeat (10) @(posedge clk);
        #1;
        check("sat_cnt10", 128'(sat_count), 128'(10));
        check("sat_idx10", 128'(sat_index), 128'(1));
        repeat (65520) @(posedge clk);
        #1;
        check("sat_cnt65530", 128'(sat_count), 128'(65530));
        repeat (5) @(posedge clk);
        #1;
        check("sat_cnt_max", 128'(sat_count), 128'(16'hFFFF));
        repeat (20) @(posedge clk);
        #1;
        check("sat_cnt_hold", 128'(sat_count), 128'(16'hFFFF));
        check("sat_valid", 128'(sat_valid), 128'(1));
        sat_hit = '0;
    endtask

    initial begin
        rst    = 1'b1;
        sof    = 1'b0;
        hit    = '0;
        speeds = '0;
        for (int i = 0; i < NCELLS; i++) nums[i] = 4'($urandom_range(0, 9));
        sat_rst = 1'b1;
        sat_hit = '0;
        fork
            main_seq();
            sat_seq();
        join
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
